fetch_queue: RTL and testbench

Instruction queue between the fetch stage and decode. Captures {PC, instruction} pairs produced by fetch each cycle, buffers up to `depth` entries, and presents them in order to decode with a valid/ready handshake. Generates the fetch stall when full and discards all buffered entries on a redirect (branch or exception). This decouples decode back-pressure from the PC register.

---
 rtl/fetch_queue.sv | 100 ++++++++++
 tb/tb_fetch_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : In-order {PC, instruction} buffer between fetch and decode with
//             valid/ready handshake, full stall and redirect flush.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter int width = 32,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid,
    input  logic [width-1:0]         pc_in,
    input  logic [width-1:0]         instr_in,
    input  logic                     flush,
    output logic                     stall_f,
    input  logic                     dec_ready,
    output logic                     dec_valid,
    output logic [width-1:0]         pc_out,
    output logic [width-1:0]         instr_out,
    output logic [$clog2(depth):0]   count
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    FULL_COUNT = CW'(depth);
    localparam logic [width-1:0] NOP_INSTR  = width'(32'h0000_0013);

    logic [width-1:0] pc_mem_q    [depth];
    logic [width-1:0] instr_mem_q [depth];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // A full queue refuses the push even when decode pops in the same cycle.
    assign push = fetch_valid & ~full & ~flush;
    assign pop  = ~empty & dec_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observable once counted valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem_q[wr_ptr_q]    <= pc_in;
            instr_mem_q[wr_ptr_q] <= instr_in;
        end
    end

    assign stall_f   = full;
    assign dec_valid = ~empty;
    assign count     = count_q;
    assign pc_out    = empty ? '0        : pc_mem_q[rd_ptr_q];
    assign instr_out = empty ? NOP_INSTR : instr_mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Directed self-checking bench for fetch_queue (width 32, depth 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic              clk;
    logic              reset;
    logic              fetch_valid;
    logic [WIDTH-1:0]  pc_in;
    logic [WIDTH-1:0]  instr_in;
    logic              flush;
    logic              stall_f;
    logic              dec_ready;
    logic              dec_valid;
    logic [WIDTH-1:0]  pc_out;
    logic [WIDTH-1:0]  instr_out;
    logic [2:0]        count;

    int n_tests;
    int n_failed;

    fetch_queue #(
        .width (WIDTH),
        .depth (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .pc_in       (pc_in),
        .instr_in    (instr_in),
        .flush       (flush),
        .stall_f     (stall_f),
        .dec_ready   (dec_ready),
        .dec_valid   (dec_valid),
        .pc_out      (pc_out),
        .instr_out   (instr_out),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".count"},     32'(count),     32'd0);
        check({tag, ".stall_f"},   32'(stall_f),   32'd0);
        check({tag, ".dec_valid"}, 32'(dec_valid), 32'd0);
        check({tag, ".pc_out"},    pc_out,         32'h0);
        check({tag, ".instr_out"}, instr_out,      32'h0000_0013);
    endtask

    initial begin
        n_tests     = 0;
        n_failed    = 0;
        reset       = 1'b1;
        fetch_valid = 1'b0;
        pc_in       = '0;
        instr_in    = '0;
        flush       = 1'b0;
        dec_ready   = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_reset_state("reset");

        // Fill to full, then a refused fifth push
        fetch_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc_in    = 32'(i * 4);
            instr_in = 32'h1000 + 32'(i);
            step();
            check("fill.count", 32'(count), 32'(i + 1));
        end
        check("fill.stall_f", 32'(stall_f), 32'd1);
        pc_in    = 32'h10;
        instr_in = 32'h1004;
        step();
        check("fill.refused_count", 32'(count), 32'd4);
        check("fill.head_pc", pc_out, 32'h0);

        // Drain in order
        fetch_valid = 1'b0;
        dec_ready   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain.pc",    pc_out,    32'(i * 4));
            check("drain.instr", instr_out, 32'h1000 + 32'(i));
            step();
        end
        check("drain.dec_valid", 32'(dec_valid), 32'd0);
        check("drain.instr_nop", instr_out, 32'h0000_0013);
        check("drain.count",     32'(count), 32'd0);
        step();
        check("empty_pop_ignored", 32'(count), 32'd0);

        // Streaming across pointer wrap
        fetch_valid = 1'b1;
        dec_ready   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pc_in    = 32'(i * 4);
            instr_in = 32'h2000 + 32'(i);
            step();
            check("stream.count", 32'(count), 32'd1);
            check("stream.pc",    pc_out,     32'(i * 4));
        end
        fetch_valid = 1'b0;
        step();
        check("stream.drained", 32'(count), 32'd0);

        // Full with simultaneous pop: pop happens, push refused
        dec_ready   = 1'b0;
        fetch_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc_in    = 32'h100 + 32'(i * 4);
            instr_in = 32'h3000 + 32'(i);
            step();
        end
        check("fullpop.pre_count", 32'(count), 32'd4);
        pc_in     = 32'h10;
        instr_in  = 32'h3010;
        dec_ready = 1'b1;
        step();
        check("fullpop.count",   32'(count),   32'd3);
        check("fullpop.stall_f", 32'(stall_f), 32'd0);
        check("fullpop.head",    pc_out,       32'h104);
        dec_ready = 1'b0;
        step();
        check("fullpop.accept_count", 32'(count), 32'd4);
        fetch_valid = 1'b0;
        dec_ready   = 1'b1;
        step();
        step();
        step();
        check("fullpop.tail_pc",    pc_out,    32'h10);
        check("fullpop.tail_instr", instr_out, 32'h3010);
        step();
        check("fullpop.empty", 32'(count), 32'd0);

        // Flush drops queue and the presented instruction
        dec_ready   = 1'b0;
        fetch_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_in    = 32'h20 + 32'(i * 4);
            instr_in = 32'h4000 + 32'(i);
            step();
        end
        check("flush.pre_count", 32'(count), 32'd3);
        flush    = 1'b1;
        pc_in    = 32'h80;
        instr_in = 32'h4080;
        step();
        flush = 1'b0;
        check("flush.count",     32'(count),     32'd0);
        check("flush.dec_valid", 32'(dec_valid), 32'd0);
        pc_in    = 32'h200;
        instr_in = 32'h4200;
        step();
        fetch_valid = 1'b0;
        check("flush.new_pc",    pc_out,     32'h200);
        check("flush.new_instr", instr_out,  32'h4200);
        check("flush.new_count", 32'(count), 32'd1);

        // Reset mid-stream with push and pop active
        fetch_valid = 1'b1;
        pc_in       = 32'h300;
        instr_in    = 32'h5000;
        step();
        check("midreset.pre_count", 32'(count), 32'd2);
        dec_ready = 1'b1;
        pc_in     = 32'h304;
        reset     = 1'b1;
        step();
        reset       = 1'b0;
        fetch_valid = 1'b0;
        dec_ready   = 1'b0;
        check_reset_state("midreset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
`default_nettype wire
